// File: rtl/commit_arbiter_pkg.sv
// commit_arbiter_pkg: shared sizes, channel indices and commit beat layout
package commit_arbiter_pkg;

    localparam int DEF_NUM_REQS    = 5;
    localparam int DEF_NUM_THREADS = 4;
    localparam int DEF_NW_BITS     = 2;
    localparam int DEF_NR_BITS     = 5;
    localparam int DEF_UUID_BITS   = 44;

    localparam int EX_ALU = 0;
    localparam int EX_LSU = 1;
    localparam int EX_CSR = 2;
    localparam int EX_FPU = 3;
    localparam int EX_GPU = 4;

    localparam int COMMIT_DATAW = DEF_UUID_BITS + DEF_NW_BITS + DEF_NUM_THREADS + 32
                                + DEF_NR_BITS + DEF_NUM_THREADS * 32 + 1;

    typedef struct packed {
        logic [DEF_UUID_BITS-1:0]      uuid;
        logic [DEF_NW_BITS-1:0]        wid;
        logic [DEF_NUM_THREADS-1:0]    tmask;
        logic [31:0]                   pc;
        logic [DEF_NR_BITS-1:0]        rd;
        logic [DEF_NUM_THREADS*32-1:0] data;
        logic                          eop;
    } commit_t;

endpackage

// File: rtl/commit_skid_buf.sv
// commit_skid_buf: 2-entry skid buffer; output and input-ready are both registered
module commit_skid_buf #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data
);

    logic             skid_v;
    logic [DATAW-1:0] skid_d;

    assign in_ready = !skid_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            skid_v    <= 1'b0;
            skid_d    <= '0;
        end else if (!out_valid || out_ready) begin
            out_valid <= skid_v || in_valid;
            if (skid_v)
                out_data <= skid_d;
            else if (in_valid)
                out_data <= in_data;
            skid_v <= 1'b0;
        end else if (in_valid && in_ready) begin
            // output stalled: park the beat so ready can stay registered
            skid_v <= 1'b1;
            skid_d <= in_data;
        end
    end

endmodule

// File: rtl/commit_arbiter.sv
// commit_arbiter: round-robin fan-in of execution-unit commit beats onto the
// single writeback port, with per-packet lock and the instret counter
module commit_arbiter
    import commit_arbiter_pkg::*;
#(
    parameter int NUM_REQS    = DEF_NUM_REQS,
    parameter int NUM_THREADS = DEF_NUM_THREADS,
    parameter int NW_BITS     = DEF_NW_BITS,
    parameter int NR_BITS     = DEF_NR_BITS,
    parameter int UUID_BITS   = DEF_UUID_BITS
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_REQS-1:0]                req_valid,
    output logic [NUM_REQS-1:0]                req_ready,
    input  logic [NUM_REQS*UUID_BITS-1:0]      req_uuid,
    input  logic [NUM_REQS*NW_BITS-1:0]        req_wid,
    input  logic [NUM_REQS*NUM_THREADS-1:0]    req_tmask,
    input  logic [NUM_REQS*32-1:0]             req_PC,
    input  logic [NUM_REQS*NR_BITS-1:0]        req_rd,
    input  logic [NUM_REQS-1:0]                req_wb,
    input  logic [NUM_REQS*NUM_THREADS*32-1:0] req_data,
    input  logic [NUM_REQS-1:0]                req_eop,
    output logic                               wb_valid,
    input  logic                               wb_ready,
    output logic [UUID_BITS-1:0]               wb_uuid,
    output logic [NW_BITS-1:0]                 wb_wid,
    output logic [NUM_THREADS-1:0]             wb_tmask,
    output logic [31:0]                        wb_PC,
    output logic [NR_BITS-1:0]                 wb_rd,
    output logic [NUM_THREADS*32-1:0]          wb_data,
    output logic                               wb_eop,
    output logic                               commit_valid,
    output logic [NW_BITS-1:0]                 commit_wid,
    output logic [63:0]                        instret
);

    localparam int IDXW  = $clog2(NUM_REQS);
    localparam int DATAW = UUID_BITS + NW_BITS + NUM_THREADS + 32 + NR_BITS + NUM_THREADS * 32 + 1;

    logic [IDXW-1:0]    rr_ptr, lock_id, rr_idx, gnt_idx;
    logic               lock, rr_hit, gnt_v, sel_wb, sel_eop, fire, buf_ready;
    logic [NW_BITS-1:0] sel_wid;
    logic [DATAW-1:0]   buf_in, buf_out;
    logic [63:0]        instret_q;

    // lowest offset from rr_ptr wins, so scan offsets from high to low
    always_comb begin
        rr_hit = 1'b0;
        rr_idx = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            if (req_valid[IDXW'((int'(rr_ptr) + k) % NUM_REQS)]) begin
                rr_hit = 1'b1;
                rr_idx = IDXW'((int'(rr_ptr) + k) % NUM_REQS);
            end
        end
    end

    assign gnt_idx = lock ? lock_id : rr_idx;
    assign gnt_v   = reset && (lock ? req_valid[lock_id] : rr_hit);
    assign sel_wb  = req_wb[gnt_idx];
    assign sel_eop = req_eop[gnt_idx];
    assign sel_wid = req_wid[gnt_idx*NW_BITS +: NW_BITS];
    // retire-only beats bypass the buffer and never wait on its space
    assign fire    = gnt_v && (!sel_wb || buf_ready);

    always_comb begin
        req_ready          = '0;
        req_ready[gnt_idx] = fire;
    end

    assign buf_in = {req_uuid[gnt_idx*UUID_BITS +: UUID_BITS],
                     sel_wid,
                     req_tmask[gnt_idx*NUM_THREADS +: NUM_THREADS],
                     req_PC[gnt_idx*32 +: 32],
                     req_rd[gnt_idx*NR_BITS +: NR_BITS],
                     req_data[gnt_idx*NUM_THREADS*32 +: NUM_THREADS*32],
                     sel_eop};

    commit_skid_buf #(
        .DATAW(DATAW)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .in_valid (fire && sel_wb),
        .in_ready (buf_ready),
        .in_data  (buf_in),
        .out_valid(wb_valid),
        .out_ready(wb_ready),
        .out_data (buf_out)
    );

    assign {wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop} = buf_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            lock         <= 1'b0;
            lock_id      <= '0;
            commit_valid <= 1'b0;
            commit_wid   <= '0;
            instret_q    <= '0;
        end else begin
            commit_valid <= fire && sel_eop;
            if (fire) begin
                lock    <= !sel_eop;
                lock_id <= gnt_idx;
                if (sel_eop) begin
                    rr_ptr     <= (gnt_idx == IDXW'(NUM_REQS - 1)) ? '0 : gnt_idx + 1'b1;
                    commit_wid <= sel_wid;
                    instret_q  <= instret_q + 64'd1;
                end
            end
        end
    end

    assign instret = instret_q;

endmodule

// File: tb/tb_commit_arbiter.sv
// tb_commit_arbiter: scenario tasks plus a writeback/commit scoreboard for commit_arbiter
module tb_commit_arbiter;
    import commit_arbiter_pkg::*;

    localparam int N  = DEF_NUM_REQS;
    localparam int T  = DEF_NUM_THREADS;
    localparam int WB = DEF_NW_BITS;
    localparam int RB = DEF_NR_BITS;
    localparam int UB = DEF_UUID_BITS;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid = '0, req_ready, req_wb = '0, req_eop = '0;
    logic [N*UB-1:0]   req_uuid = '0;
    logic [N*WB-1:0]   req_wid = '0;
    logic [N*T-1:0]    req_tmask = '0;
    logic [N*32-1:0]   req_PC = '0;
    logic [N*RB-1:0]   req_rd = '0;
    logic [N*T*32-1:0] req_data = '0;
    logic              wb_valid, wb_ready = 1'b1, wb_eop, commit_valid;
    logic [UB-1:0]     wb_uuid;
    logic [WB-1:0]     wb_wid, commit_wid;
    logic [T-1:0]      wb_tmask;
    logic [31:0]       wb_PC;
    logic [RB-1:0]     wb_rd;
    logic [T*32-1:0]   wb_data;
    logic [63:0]       instret;

    int          checks = 0, failures = 0;
    int          seq = 0;
    commit_t     exp_q[$];
    logic [WB-1:0] cm_q[$];
    logic [63:0] exp_instret = '0;
    commit_t     got, e;
    logic [WB-1:0] ew;

    always #5 clk = ~clk;

    commit_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_uuid(req_uuid), .req_wid(req_wid),
        .req_tmask(req_tmask), .req_PC(req_PC), .req_rd(req_rd), .req_wb(req_wb),
        .req_data(req_data), .req_eop(req_eop),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_uuid(wb_uuid), .wb_wid(wb_wid),
        .wb_tmask(wb_tmask), .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
        .commit_valid(commit_valid), .commit_wid(commit_wid), .instret(instret)
    );

    // scoreboard: pop on writeback transfer and on commit pulse, push on each accept
    always @(negedge clk) begin
        if (reset) begin
            if (wb_valid && wb_ready) begin
                checks++;
                got = {wb_uuid, wb_wid, wb_tmask, wb_PC, wb_rd, wb_data, wb_eop};
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_wb_unexpected got=%h", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        failures++;
                        $display("FAIL sb_wb_beat got=%h exp=%h", got, e);
                    end
                end
            end
            checks++;
            if (commit_valid !== (cm_q.size() != 0)) begin
                failures++;
                $display("FAIL sb_commit_valid got=%b exp=%b", commit_valid, cm_q.size() != 0);
                if (cm_q.size() != 0) void'(cm_q.pop_front());
            end else if (commit_valid) begin
                ew = cm_q.pop_front();
                checks++;
                if (commit_wid !== ew || instret !== exp_instret) begin
                    failures++;
                    $display("FAIL sb_commit got wid=%0d instret=%0h exp wid=%0d instret=%0h",
                             commit_wid, instret, ew, exp_instret);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (req_wb[i])
                        exp_q.push_back({req_uuid[i*UB +: UB], req_wid[i*WB +: WB], req_tmask[i*T +: T],
                                         req_PC[i*32 +: 32], req_rd[i*RB +: RB], req_data[i*T*32 +: T*32],
                                         req_eop[i]});
                    if (req_eop[i]) begin
                        exp_instret = exp_instret + 64'd1;
                        cm_q.push_back(req_wid[i*WB +: WB]);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input bit v, input bit wb, input bit eop,
                         input logic [WB-1:0] wid, input logic [RB-1:0] rd, input logic [31:0] lane);
        seq++;
        req_valid[i]              = v;
        req_wb[i]                 = wb;
        req_eop[i]                = eop;
        req_wid[i*WB +: WB]       = wid;
        req_rd[i*RB +: RB]        = rd;
        req_uuid[i*UB +: UB]      = {12'(i), 32'(seq)};
        req_tmask[i*T +: T]       = lane[3:0];
        req_PC[i*32 +: 32]        = 32'h8000_0000 + lane;
        req_data[i*T*32 +: T*32]  = {T{lane}};
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0;
        wb_ready = 1'b1;
        exp_q.delete();
        cm_q.delete();
        exp_instret = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_drain();
        req_valid = '0;
        wb_ready = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || cm_q.size() != 0); c++) step();
        step();
        checks++;
        if (exp_q.size() != 0 || cm_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending wb=%0d commit=%0d exp 0", exp_q.size(), cm_q.size());
        end
    endtask

    task automatic test_reset();
        drive(EX_ALU, 1, 1, 1, 2'd0, 5'd1, 32'h1);
        #3;
        checks++;
        if (wb_valid !== 1'b0 || commit_valid !== 1'b0 || commit_wid !== '0 || instret !== 64'd0) begin
            failures++;
            $display("FAIL reset_state got wb_valid=%b commit_valid=%b wid=%0d instret=%0h exp 0",
                     wb_valid, commit_valid, commit_wid, instret);
        end
        checks++;
        if (req_ready !== 5'b00000) begin
            failures++;
            $display("FAIL reset_ready got=%b exp=00000", req_ready);
        end
        req_valid = '0;
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_single();
        drive(EX_ALU, 1, 1, 1, 2'd1, 5'd5, 32'hA5);
        @(negedge clk);
        checks++;
        if (req_ready !== 5'b00001) begin
            failures++;
            $display("FAIL single_ready got=%b exp=00001", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== {T{32'hA5}}) begin
            failures++;
            $display("FAIL single_wb got valid=%b rd=%0d data=%h exp 1 5 %h", wb_valid, wb_rd, wb_data, {T{32'hA5}});
        end
        checks++;
        if (commit_valid !== 1'b1 || commit_wid !== 2'd1 || instret !== 64'd1) begin
            failures++;
            $display("FAIL single_commit got valid=%b wid=%0d instret=%0d exp 1 1 1", commit_valid, commit_wid, instret);
        end
        test_drain();
    endtask

    task automatic test_contention();
        int order[3] = '{0, 2, 4};
        int cnt[N] = '{default: 0};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            drive(EX_ALU, 1, 1, 1, 2'd0, 5'(k), 32'h100 + k);
            drive(EX_CSR, 1, 1, 1, 2'd2, 5'(k), 32'h200 + k);
            drive(EX_GPU, 1, 1, 1, 2'd3, 5'(k), 32'h400 + k);
            @(negedge clk);
            checks++;
            if (req_ready !== 5'(1 << order[k % 3])) begin
                failures++;
                $display("FAIL contention_grant k=%0d got=%b exp=%b", k, req_ready, 5'(1 << order[k % 3]));
            end
            for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
            step();
        end
        checks++;
        if (cnt[0] != 3 || cnt[2] != 3 || cnt[4] != 3) begin
            failures++;
            $display("FAIL contention_share got %0d/%0d/%0d exp 3/3/3", cnt[0], cnt[2], cnt[4]);
        end
        test_drain();
    endtask

    task automatic test_lock();
        do_reset();
        drive(EX_LSU, 1, 1, 0, 2'd1, 5'd7, 32'h11);
        @(negedge clk);
        checks++;
        if (req_ready !== 5'b00010) begin
            failures++;
            $display("FAIL lock_first got=%b exp=00010", req_ready);
        end
        step();
        drive(EX_ALU, 1, 1, 1, 2'd0, 5'd3, 32'h21);
        drive(EX_LSU, 1, 1, 0, 2'd1, 5'd7, 32'h12);
        @(negedge clk);
        checks++;
        if (req_ready !== 5'b00010) begin
            failures++;
            $display("FAIL lock_hold got=%b exp=00010", req_ready);
        end
        step();
        drive(EX_LSU, 1, 1, 1, 2'd1, 5'd7, 32'h13);
        @(negedge clk);
        checks++;
        if (req_ready !== 5'b00010 || instret !== 64'd0) begin
            failures++;
            $display("FAIL lock_eop got ready=%b instret=%0d exp 00010 0", req_ready, instret);
        end
        step();
        req_valid[EX_LSU] = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 5'b00001 || instret !== 64'd1) begin
            failures++;
            $display("FAIL lock_release got ready=%b instret=%0d exp 00001 1", req_ready, instret);
        end
        step();
        test_drain();
    endtask

    task automatic test_backpressure();
        logic [4:0] exp_rdy[4] = '{5'b00001, 5'b00001, 5'b00100, 5'b00000};
        do_reset();
        wb_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(EX_ALU, 1, 1, 1, 2'd0, 5'd9, 32'hB000_0000 + c);
            if (c == 2) drive(EX_CSR, 1, 0, 1, 2'd2, 5'd0, 32'hC0);
            if (c == 3) req_valid[EX_CSR] = 1'b0;
            @(negedge clk);
            checks++;
            if (req_ready !== exp_rdy[c]) begin
                failures++;
                $display("FAIL bp_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy[c]);
            end
            if (c == 3) begin
                checks++;
                if (wb_valid !== 1'b1 || wb_data !== {T{32'hB000_0000}} || instret !== 64'd3) begin
                    failures++;
                    $display("FAIL bp_hold got valid=%b data=%h instret=%0d exp 1 %h 3",
                             wb_valid, wb_data, instret, {T{32'hB000_0000}});
                end
            end
            step();
        end
        wb_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(EX_ALU, 1, 1, 1, 2'd0, 5'd9, 32'hB100_0000 + c);
            step();
        end
        test_drain();
    endtask

    task automatic test_wrap();
        do_reset();
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.instret_q;
        step();
        drive(EX_FPU, 1, 0, 1, 2'd2, 5'd0, 32'h3);
        @(negedge clk);
        checks++;
        if (req_ready !== 5'b01000) begin
            failures++;
            $display("FAIL wrap_ready got=%b exp=01000", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (commit_valid !== 1'b1 || commit_wid !== 2'd2 || instret !== 64'd0) begin
            failures++;
            $display("FAIL wrap_instret got valid=%b wid=%0d instret=%0h exp 1 2 0", commit_valid, commit_wid, instret);
        end
        test_drain();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        wb_ready = 1'b0;
        drive(EX_GPU, 1, 1, 0, 2'd3, 5'd4, 32'h44);
        @(negedge clk);
        checks++;
        if (req_ready !== 5'b10000) begin
            failures++;
            $display("FAIL mid_lock got=%b exp=10000", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL mid_buffered got=%b exp=1", wb_valid);
        end
        #2 reset = 1'b0;
        exp_q.delete();
        cm_q.delete();
        exp_instret = '0;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || commit_valid !== 1'b0 || req_ready !== 5'b00000) begin
            failures++;
            $display("FAIL mid_reset got wb_valid=%b commit_valid=%b ready=%b exp 0 0 00000",
                     wb_valid, commit_valid, req_ready);
        end
        step();
        reset = 1'b1;
        wb_ready = 1'b1;
        drive(EX_ALU, 1, 1, 1, 2'd0, 5'd1, 32'h51);
        drive(EX_GPU, 1, 1, 1, 2'd3, 5'd2, 32'h52);
        @(negedge clk);
        checks++;
        if (req_ready !== 5'b00001) begin
            failures++;
            $display("FAIL mid_after got=%b exp=00001", req_ready);
        end
        step();
        test_drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_backpressure();
        test_wrap();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
